servo_pwm_multi: RTL and testbench

Multi-channel hobby-servo PWM generator with an Avalon-MM slave register interface. It is the parametrised successor to the single-output servo controller in the Computer_System Qsys build. It provides CHANNELS independent outputs with a shared frame, per-channel pulse width clamped to [MIN_TICKS, MAX_TICKS], an optional per-frame slew limit, and glitch-free updates at frame boundaries. Each pwm_out bit drives a GPIO/Arduino header pin at the top level.

---
 rtl/servo_pwm_multi_if.sv | 27 ++
 rtl/servo_pwm_multi.sv | 153 +++++++++++++++
 tb/tb_servo_pwm_multi.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/servo_pwm_multi_if.sv
// Avalon-MM slave bus bundle for the servo PWM register block.
// The master modport is the bus side (testbench or interconnect), slave is the peripheral.
interface servo_pwm_multi_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator with a shared frame, clamped widths,
// optional per-frame slew limiting and frame-boundary updates over Avalon-MM.
module servo_pwm_multi #(
  parameter int CHANNELS    = 4,
  parameter int ADDR_W      = 3,
  parameter int PW_WIDTH    = 16,
  parameter int TICK_DIV    = 50,
  parameter int FRAME_TICKS = 20000,
  parameter int MIN_TICKS   = 1000,
  parameter int MAX_TICKS   = 2000,
  parameter int SLEW_STEP   = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  servo_pwm_multi_if.slave    avs,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_pulse
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0]        PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PW_WIDTH-1:0]     FRM_LAST  = PW_WIDTH'(FRAME_TICKS - 1);
  localparam logic [PW_WIDTH-1:0]     MIN_PW    = PW_WIDTH'(MIN_TICKS);
  localparam logic [PW_WIDTH-1:0]     MAX_PW    = PW_WIDTH'(MAX_TICKS);
  localparam logic [PW_WIDTH-1:0]     CENTER_PW = PW_WIDTH'((MIN_TICKS + MAX_TICKS) / 2);
  localparam logic [PW_WIDTH-1:0]     STEP_PW   = PW_WIDTH'(SLEW_STEP);
  localparam logic signed [PW_WIDTH:0] STEP_S   = (PW_WIDTH+1)'(SLEW_STEP);
  localparam logic [ADDR_W-1:0]       CTRL_ADDR = ADDR_W'(CHANNELS);
  localparam logic [ADDR_W-1:0]       STAT_ADDR = ADDR_W'(CHANNELS + 1);

  function automatic logic [PW_WIDTH-1:0] clamp_pw(input logic [PW_WIDTH-1:0] v);
    if (v < MIN_PW) return MIN_PW;
    if (v > MAX_PW) return MAX_PW;
    return v;
  endfunction

  function automatic logic [PW_WIDTH-1:0] slew_pw(input logic [PW_WIDTH-1:0] tgt,
                                                  input logic [PW_WIDTH-1:0] act);
    logic signed [PW_WIDTH:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, act});
    if (diff > STEP_S)  return act + STEP_PW;
    if (diff < -STEP_S) return act - STEP_PW;
    return tgt;
  endfunction

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [PW_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                ctrl_en_q, ctrl_en_d;
  logic                ctrl_slew_q, ctrl_slew_d;
  logic                active_en_q, active_en_d;
  logic [PW_WIDTH-1:0] target_q [CHANNELS];
  logic [PW_WIDTH-1:0] target_d [CHANNELS];
  logic [PW_WIDTH-1:0] active_q [CHANNELS];
  logic [PW_WIDTH-1:0] active_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                frame_pulse_q, frame_pulse_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         rd_mux;

  logic tick;
  logic boundary;
  logic wr_ctrl;
  logic kill;
  logic unused_wdata;

  assign unused_wdata = ^avs.avs_writedata[31:PW_WIDTH];

  always_comb begin
    tick     = (presc_q == PRE_LAST);
    boundary = tick && (frame_cnt_q == FRM_LAST);
    wr_ctrl  = avs.avs_write && (avs.avs_address == CTRL_ADDR);
    kill     = wr_ctrl && !avs.avs_writedata[0];

    presc_d = tick ? '0 : presc_q + 1'b1;

    frame_cnt_d = frame_cnt_q;
    if (boundary)  frame_cnt_d = '0;
    else if (tick) frame_cnt_d = frame_cnt_q + 1'b1;

    frame_count_d = boundary ? frame_count_q + 16'd1 : frame_count_q;
    frame_pulse_d = boundary;

    ctrl_en_d   = wr_ctrl ? avs.avs_writedata[0] : ctrl_en_q;
    ctrl_slew_d = wr_ctrl ? avs.avs_writedata[1] : ctrl_slew_q;

    // Enabling waits for a boundary; disabling is immediate so outputs drop next cycle.
    active_en_d = active_en_q;
    if (boundary) active_en_d = ctrl_en_q;
    if (kill)     active_en_d = 1'b0;

    for (int i = 0; i < CHANNELS; i++) begin
      target_d[i] = target_q[i];
      if (avs.avs_write && (avs.avs_address == ADDR_W'(i)))
        target_d[i] = clamp_pw(avs.avs_writedata[PW_WIDTH-1:0]);

      // Boundary load uses the registered target, so a same-cycle write waits a frame.
      active_d[i] = active_q[i];
      if (boundary)
        active_d[i] = ctrl_slew_q ? slew_pw(target_q[i], active_q[i]) : target_q[i];

      pwm_d[i] = active_en_q && !kill && (frame_cnt_q < active_q[i]);
    end

    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (avs.avs_address == ADDR_W'(i))
        rd_mux = {{(32-PW_WIDTH){1'b0}}, target_q[i]};
    end
    if (avs.avs_address == CTRL_ADDR) rd_mux = {30'd0, ctrl_slew_q, ctrl_en_q};
    if (avs.avs_address == STAT_ADDR) rd_mux = {active_en_q, 15'd0, frame_count_q};

    rdata_d = avs.avs_read ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q       <= '0;
      frame_cnt_q   <= '0;
      frame_count_q <= '0;
      ctrl_en_q     <= 1'b0;
      ctrl_slew_q   <= 1'b0;
      active_en_q   <= 1'b0;
      pwm_q         <= '0;
      frame_pulse_q <= 1'b0;
      rdata_q       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        target_q[i] <= CENTER_PW;
        active_q[i] <= CENTER_PW;
      end
    end else begin
      presc_q       <= presc_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_count_q <= frame_count_d;
      ctrl_en_q     <= ctrl_en_d;
      ctrl_slew_q   <= ctrl_slew_d;
      active_en_q   <= active_en_d;
      pwm_q         <= pwm_d;
      frame_pulse_q <= frame_pulse_d;
      rdata_q       <= rdata_d;
      for (int i = 0; i < CHANNELS; i++) begin
        target_q[i] <= target_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign pwm_out          = pwm_q;
  assign frame_pulse      = frame_pulse_q;
  assign avs.avs_readdata = rdata_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi with small tick/frame parameters
// (2 cycles per tick, 100 ticks per frame, widths clamped to 10..20).
module tb_servo_pwm_multi;

  localparam int CH = 4;

  logic          clk;
  logic          reset_n;
  logic [CH-1:0] pwm_out;
  logic          frame_pulse;

  int checks   = 0;
  int failures = 0;
  int width_c [CH];
  int fp_c;
  logic [31:0] rd_val;
  logic [31:0] stat0;

  servo_pwm_multi_if #(.ADDR_W(3)) bus ();

  servo_pwm_multi #(
    .CHANNELS(CH), .ADDR_W(3), .PW_WIDTH(16), .TICK_DIV(2), .FRAME_TICKS(100),
    .MIN_TICKS(10), .MAX_TICKS(20), .SLEW_STEP(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avs(bus.slave),
    .pwm_out(pwm_out),
    .frame_pulse(frame_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    bus.avs_address   = addr;
    bus.avs_writedata = data;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] addr, output logic [31:0] data);
    bus.avs_address = addr;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    data            = bus.avs_readdata;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!frame_pulse && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!frame_pulse) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  // Samples one full 200-cycle frame starting at the frame_pulse cycle.
  task automatic measure();
    for (int c = 0; c < CH; c++) width_c[c] = 0;
    fp_c = 0;
    for (int n = 0; n < 200; n++) begin
      for (int c = 0; c < CH; c++) if (pwm_out[c]) width_c[c]++;
      if (frame_pulse) fp_c++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n           = 1'b0;
    bus.avs_address   = '0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read      = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    chk("rst_pwm", {28'd0, pwm_out}, 32'd0);
    chk("rst_fp", {31'd0, frame_pulse}, 32'd0);
    chk("rst_rdata", bus.avs_readdata, 32'd0);
    rd(3'd5, rd_val); chk("rst_status", rd_val, 32'd0);
    rd(3'd0, rd_val); chk("rst_target0", rd_val, 32'd15);
    rd(3'd4, rd_val); chk("rst_ctrl", rd_val, 32'd0);
    wr(3'd7, 32'd123);
    rd(3'd7, rd_val); chk("unmapped_rd", rd_val, 32'd0);

    // 1: enable, centre pulses
    wr(3'd4, 32'd1);
    wait_frame();
    measure();
    for (int c = 0; c < CH; c++) chk($sformatf("t1_w%0d", c), width_c[c], 32'd30);
    chk("t1_fp_count", fp_c, 32'd1);
    chk("t1_fp_period", {31'd0, frame_pulse}, 32'd1);
    rd(3'd5, rd_val); chk("t1_active_en", {31'd0, rd_val[31]}, 32'd1);

    // 2: clamping
    wr(3'd0, 32'd5);
    wr(3'd1, 32'd99);
    rd(3'd0, rd_val); chk("t2_rd_t0", rd_val, 32'd10);
    rd(3'd1, rd_val); chk("t2_rd_t1", rd_val, 32'd20);
    wait_frame();
    measure();
    chk("t2_w0", width_c[0], 32'd20);
    chk("t2_w1", width_c[1], 32'd40);
    chk("t2_w2", width_c[2], 32'd30);

    // 3: slew 15 -> 20 in steps of 2
    wr(3'd4, 32'd3);
    wr(3'd2, 32'd20);
    wait_frame();
    measure(); chk("t3_f1", width_c[2], 32'd34);
    measure(); chk("t3_f2", width_c[2], 32'd38);
    measure(); chk("t3_f3", width_c[2], 32'd40);
    measure(); chk("t3_f4", width_c[2], 32'd40);

    // 4: target write on the boundary edge
    wr(3'd4, 32'd1);
    repeat (198) @(negedge clk);
    wr(3'd3, 32'd12);
    chk("t4_fp_align", {31'd0, frame_pulse}, 32'd1);
    measure(); chk("t4_same_frame", width_c[3], 32'd30);
    measure(); chk("t4_next_frame", width_c[3], 32'd24);

    // 5: disable mid-pulse
    repeat (5) @(negedge clk);
    chk("t5_pwm_high", {28'd0, pwm_out}, 32'hF);
    wr(3'd4, 32'd0);
    chk("t5_pwm_low", {28'd0, pwm_out}, 32'd0);
    rd(3'd5, stat0);
    chk("t5_active_en", {31'd0, stat0[31]}, 32'd0);
    wait_frame();
    rd(3'd5, rd_val);
    chk("t5_frame_count", {16'd0, rd_val[15:0]}, {16'd0, stat0[15:0] + 16'd1});
    measure(); chk("t5_disabled_w0", width_c[0], 32'd0);

    // 6: same-cycle read/write, then mid-frame reset
    wr(3'd4, 32'd1);
    wait_frame();
    repeat (3) @(negedge clk);
    chk("t6_pwm_high", {28'd0, pwm_out}, 32'hF);
    bus.avs_address   = 3'd1;
    bus.avs_writedata = 32'd12;
    bus.avs_write     = 1'b1;
    bus.avs_read      = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
    bus.avs_read      = 1'b0;
    chk("t6_rw_prewrite", bus.avs_readdata, 32'd20);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("t6_pwm_rst", {28'd0, pwm_out}, 32'd0);
    chk("t6_fp_rst", {31'd0, frame_pulse}, 32'd0);
    chk("t6_rdata_rst", bus.avs_readdata, 32'd0);
    rd(3'd5, rd_val); chk("t6_status", rd_val, 32'd0);
    rd(3'd1, rd_val); chk("t6_target1", rd_val, 32'd15);
    rd(3'd4, rd_val); chk("t6_ctrl", rd_val, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
